// File: rtl/rip_bp_counter_table.sv
// Saturating-counter direction predictor with bimodal or gshare indexing,
// a speculative global history register with mispredict recovery, and a power-on sweep.
module rip_bp_counter_table #(
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 2,
    parameter int HISTORY_LEN   = INDEX_WIDTH,
    parameter int GSHARE        = 1,
    parameter int PC_LSB        = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     ready,
    input  logic                     pred_valid,
    input  logic [31:0]              pred_pc,
    output logic                     resp_valid,
    output logic                     resp_taken,
    output logic [COUNTER_WIDTH-1:0] resp_counter,
    output logic [INDEX_WIDTH-1:0]   resp_index,
    output logic [HISTORY_LEN-1:0]   resp_ghr,
    input  logic                     upd_valid,
    input  logic [INDEX_WIDTH-1:0]   upd_index,
    input  logic                     upd_taken,
    input  logic                     upd_mispredict,
    input  logic [HISTORY_LEN-1:0]   upd_ghr
);

    // state    | meaning
    // ST_INIT  | sweeping WEAK_NT into every entry, requests ignored
    // ST_READY | lookups and updates accepted, held until reset
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam int                     DEPTH      = 1 << INDEX_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] WEAK_NT  = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_ENTRY = '1;
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE    = INDEX_WIDTH'(1);

    logic [0:0]               state;
    logic [INDEX_WIDTH-1:0]   sweep;
    logic [HISTORY_LEN-1:0]   ghr;
    logic [COUNTER_WIDTH-1:0] cnt_table [DEPTH];

    logic [INDEX_WIDTH-1:0]   base_index;
    logic [INDEX_WIDTH-1:0]   ghr_ext;
    logic [INDEX_WIDTH-1:0]   lookup_index;
    logic [COUNTER_WIDTH-1:0] upd_old;
    logic [COUNTER_WIDTH-1:0] upd_new;
    logic [COUNTER_WIDTH-1:0] read_raw;
    logic [COUNTER_WIDTH-1:0] read_cnt;
    logic                     pred_taken_now;
    logic                     accept;
    logic                     upd_fire;
    logic                     pred_fire;
    logic                     wr_en;
    logic [INDEX_WIDTH-1:0]   wr_addr;
    logic [COUNTER_WIDTH-1:0] wr_data;
    logic                     unused_pc_bits;

    // Works for HISTORY_LEN=1 too: the shift empties the register before the new bit lands.
    function automatic logic [HISTORY_LEN-1:0] shift_in(input logic [HISTORY_LEN-1:0] hist,
                                                        input logic bit_in);
        return (hist << 1) | HISTORY_LEN'(bit_in);
    endfunction

    assign ready          = (state == ST_READY);
    assign accept         = (state == ST_READY);
    assign upd_fire       = accept && upd_valid;
    assign pred_fire      = accept && pred_valid;
    assign unused_pc_bits = ^pred_pc;

    always_comb begin
        ghr_ext                    = '0;
        ghr_ext[HISTORY_LEN-1:0]   = ghr;
        base_index                 = pred_pc[PC_LSB+INDEX_WIDTH-1:PC_LSB];
        lookup_index               = (GSHARE != 0) ? (base_index ^ ghr_ext) : base_index;
    end

    always_comb begin
        upd_old = cnt_table[upd_index];
        if (upd_taken) begin
            upd_new = (upd_old == CNT_MAX) ? upd_old : upd_old + CNT_ONE;
        end else begin
            upd_new = (upd_old == CNT_ZERO) ? upd_old : upd_old - CNT_ONE;
        end
    end

    // Write-first bypass: a same-cycle update to the looked-up entry is what the lookup sees.
    always_comb begin
        read_raw       = cnt_table[lookup_index];
        read_cnt       = (upd_fire && (upd_index == lookup_index)) ? upd_new : read_raw;
        pred_taken_now = read_cnt[COUNTER_WIDTH-1];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = upd_index;
        wr_data = upd_new;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = sweep;
            wr_data = WEAK_NT;
        end else if (upd_fire) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cnt_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_INIT;
            sweep        <= '0;
            ghr          <= '0;
            resp_valid   <= 1'b0;
            resp_taken   <= 1'b0;
            resp_counter <= '0;
            resp_index   <= '0;
            resp_ghr     <= '0;
        end else begin
            resp_valid <= pred_fire;
            case (state)
                ST_INIT: begin
                    sweep <= sweep + IDX_ONE;
                    if (sweep == LAST_ENTRY) begin
                        state <= ST_READY;
                    end
                end
                default: begin
                    // Recovery overrides the speculative shift of a same-cycle lookup.
                    if (upd_fire && upd_mispredict) begin
                        ghr <= shift_in(upd_ghr, upd_taken);
                    end else if (pred_fire) begin
                        ghr <= shift_in(ghr, pred_taken_now);
                    end
                end
            endcase
            if (pred_fire) begin
                resp_taken   <= pred_taken_now;
                resp_counter <= read_cnt;
                resp_index   <= lookup_index;
                resp_ghr     <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_rip_bp_counter_table.sv
// Scoreboard bench for rip_bp_counter_table: a driver feeds directed and random traffic
// through a behavioural model; a monitor pops expected responses and compares.
module tb_rip_bp_counter_table;

    localparam int IW = 4;
    localparam int CW = 2;
    localparam int HL = 4;
    localparam int GS = 1;
    localparam int PL = 2;
    localparam int DEPTH   = 1 << IW;
    localparam int CMAX    = (1 << CW) - 1;
    localparam int WEAK    = (1 << (CW - 1)) - 1;
    localparam int TK_THR  = 1 << (CW - 1);
    localparam int HMASK   = (1 << HL) - 1;

    logic          clk;
    logic          rstn;
    logic          ready;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          resp_valid;
    logic          resp_taken;
    logic [CW-1:0] resp_counter;
    logic [IW-1:0] resp_index;
    logic [HL-1:0] resp_ghr;
    logic          upd_valid;
    logic [IW-1:0] upd_index;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [HL-1:0] upd_ghr;

    rip_bp_counter_table #(
        .INDEX_WIDTH(IW), .COUNTER_WIDTH(CW), .HISTORY_LEN(HL), .GSHARE(GS), .PC_LSB(PL)
    ) dut (
        .clk(clk), .rstn(rstn), .ready(ready),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_counter(resp_counter),
        .resp_index(resp_index), .resp_ghr(resp_ghr),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cnt;
        int taken;
        int ghr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_table[DEPTH];
    int   m_ghr   = 0;
    int   m_edges = 0;
    bit   m_ready = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one cycle after each edge, any response must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_index", int'(resp_index), e.idx);
                check("resp_counter", int'(resp_counter), e.cnt);
                check("resp_taken", int'(resp_taken), e.taken);
                check("resp_ghr", int'(resp_ghr), e.ghr);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL resp_missing: got resp_valid=0 expected 1 (index %0d) at %0t", e.idx, $time);
        end
    end

    // One clock of stimulus; the model advances across the edge that follows.
    task automatic step(input bit pv, input logic [31:0] pc, input bit uv, input int ui,
                        input bit ut, input bit um, input int ug);
        int   idx;
        int   c;
        int   tk;
        exp_t e;
        @(negedge clk);
        check("ready", int'(ready), int'(m_ready));
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_index      = IW'(ui);
        upd_taken      = ut;
        upd_mispredict = um;
        upd_ghr        = HL'(ug);
        if (m_ready) begin
            tk = 0;
            if (uv) begin
                if (ut) m_table[ui] = (m_table[ui] + 1 > CMAX) ? CMAX : m_table[ui] + 1;
                else    m_table[ui] = (m_table[ui] - 1 < 0) ? 0 : m_table[ui] - 1;
            end
            if (pv) begin
                idx = int'(pc >> PL) % DEPTH;
                if (GS != 0) idx = idx ^ m_ghr;
                c   = m_table[idx];
                tk  = (c >= TK_THR) ? 1 : 0;
                e   = '{idx: idx, cnt: c, taken: tk, ghr: m_ghr};
                exp_q.push_back(e);
            end
            if (uv && um)  m_ghr = ((ug * 2) + (ut ? 1 : 0)) & HMASK;
            else if (pv)   m_ghr = ((m_ghr * 2) + tk) & HMASK;
        end
        m_edges++;
        if (!m_ready && m_edges == DEPTH) begin
            m_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_table[i] = WEAK;
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic update(input int ui, input bit ut, input bit um, input int ug);
        step(1'b0, 32'h0, 1'b1, ui, ut, um, ug);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    function automatic logic [31:0] pc_for(input int idx);
        int b;
        b = (GS != 0) ? (idx ^ m_ghr) : idx;
        return 32'(b << PL);
    endfunction

    task automatic rand_step();
        int ui;
        bit pv;
        logic [31:0] pc;
        ui = $urandom_range(DEPTH - 1);
        pv = $urandom_range(3) != 0;
        pc = $urandom();
        if ($urandom_range(7) == 0) pc = pc_for(ui);
        step(pv, pc, $urandom_range(1) == 1, ui, $urandom_range(1) == 1,
             $urandom_range(3) == 0, int'($urandom_range(HMASK)));
    endtask

    // Asserts reset at a negedge, checks cleared outputs, releases on a later negedge.
    task automatic do_reset();
        @(negedge clk);
        pred_valid = 1'b0; upd_valid = 1'b0; pred_pc = '0; upd_index = '0;
        upd_taken = 1'b0; upd_mispredict = 1'b0; upd_ghr = '0;
        rstn = 1'b0;
        #1;
        check("rst_ready", int'(ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_taken", int'(resp_taken), 0);
        check("rst_resp_counter", int'(resp_counter), 0);
        check("rst_resp_index", int'(resp_index), 0);
        check("rst_resp_ghr", int'(resp_ghr), 0);
        exp_q.delete();
        m_ghr   = 0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        m_edges = 1;
    endtask

    initial begin
        rstn = 1'b0;
        pred_valid = 1'b0; upd_valid = 1'b0; pred_pc = '0; upd_index = '0;
        upd_taken = 1'b0; upd_mispredict = 1'b0; upd_ghr = '0;
        for (int i = 0; i < DEPTH; i++) m_table[i] = 0;

        do_reset();
        // Requests during the sweep must be ignored.
        for (int i = 1; i < DEPTH; i++) rand_step();
        for (int i = 0; i < DEPTH; i++) lookup(32'(i << PL));
        idle();

        for (int i = 0; i < 10; i++) update(5, 1'b1, 1'b0, 0);
        lookup(pc_for(5));
        for (int i = 0; i < 10; i++) update(5, 1'b0, 1'b0, 0);
        lookup(pc_for(5));
        idle();

        update(0, 1'b0, 1'b1, 4'b0101);
        lookup(32'h34);
        lookup(32'h0);
        step(1'b1, 32'h0, 1'b1, 9, 1'b1, 1'b1, 4'b0011);
        lookup(32'h0);
        idle();

        step(1'b1, pc_for(3), 1'b1, 3, 1'b1, 1'b0, 0);
        idle();

        do_reset();
        for (int i = 0; i < 8; i++) rand_step();
        do_reset();
        for (int i = 1; i < DEPTH; i++) rand_step();
        for (int i = 0; i < DEPTH; i++) lookup(pc_for(i));
        idle();

        for (int i = 0; i < 600; i++) rand_step();
        idle();
        idle();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rip_bp_counter_table.md
# rip_bp_counter_table

Parametrised saturating-counter direction predictor for the RIP fetch stage, the successor to the fixed 2-bit bimodal/gshare table. Counter width, table depth, history length and indexing mode (bimodal or gshare) are parameters. It holds a speculative global history register with mispredict recovery. After reset it self-initialises the table with a sweep FSM. It answers one lookup per cycle with one-cycle latency and accepts one resolved-branch update per cycle from execute.

## Interface
- INDEX_WIDTH, 10, table index bits; depth = 2**INDEX_WIDTH
- COUNTER_WIDTH, 2, bits per saturating counter, legal 1..8
- HISTORY_LEN, INDEX_WIDTH, global history bits, legal 1..INDEX_WIDTH
- GSHARE, 1, 0 = bimodal index, 1 = gshare index
- PC_LSB, 2, lowest PC bit used for indexing
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ready  out  1  table initialised, lookups/updates accepted
- pred_valid  in  1  lookup request
- pred_pc  in  32  PC of fetched branch
- resp_valid  out  1  lookup result valid
- resp_taken  out  1  predicted direction (counter MSB)
- resp_counter  out  COUNTER_WIDTH  counter value read
- resp_index  out  INDEX_WIDTH  index used; returned later on update
- resp_ghr  out  HISTORY_LEN  history before this prediction was shifted in; checkpoint for recovery
- upd_valid  in  1  resolved branch update
- upd_index  in  INDEX_WIDTH  index from resp_index
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  actual != predicted
- upd_ghr  in  HISTORY_LEN  resp_ghr of the resolving branch

## Operation
- FSM states INIT and READY. Reset enters INIT with the sweep counter at 0, GHR at 0 and all outputs at 0.
- INIT writes WEAK_NT = 2**(COUNTER_WIDTH-1)-1 to entry sweep, one entry per cycle. The last entry is written in cycle 2**INDEX_WIDTH-1, then the FSM goes to READY. For COUNTER_WIDTH=1, WEAK_NT=0.
- During INIT, ready=0 and pred_valid/upd_valid are ignored: no response, no table or GHR change.
- READY is held until reset. Reset in any state, mid-sweep included, restarts INIT from entry 0.
- Index: base = pred_pc[PC_LSB+INDEX_WIDTH-1:PC_LSB]. When GSHARE=1, index = base XOR GHR zero-extended to INDEX_WIDTH.
- Update, when upd_valid in READY:
  - upd_taken=1: counter = min(counter+1, 2**COUNTER_WIDTH-1).
  - upd_taken=0: counter = max(counter-1, 0).
  - Saturation is required; no wrap.
- GHR (shift-left, newest bit at [0]):
  - Accepted lookup shifts in the predicted direction: GHR <= {GHR[HISTORY_LEN-2:0], pred_taken_now}.
  - upd_valid with upd_mispredict=1 restores GHR <= {upd_ghr[HISTORY_LEN-2:0], upd_taken}. This wins over a same-cycle lookup shift.
  - Non-mispredict updates do not touch GHR.
  - HISTORY_LEN=1: the shift is GHR <= new bit.
- Same-cycle lookup and update to the same index: the lookup sees the post-update counter (write-first bypass). resp_counter and resp_taken reflect the bypassed value, and that value also drives the GHR shift.
- Lookup in a recovery cycle: the index uses the pre-recovery GHR, and resp_ghr reports the pre-recovery GHR.

## Timing
- Reset values: ready=0, resp_valid=0, resp_taken=0, resp_counter=0, resp_index=0, resp_ghr=0.
- ready rises on the first clock edge after the last sweep write, exactly 2**INDEX_WIDTH edges after rstn deasserts.
- Lookup latency is 1: a request sampled at edge t yields resp_* registered at edge t, valid during cycle t+1.
- resp_valid is high for exactly one cycle per accepted request. Back-to-back requests give back-to-back responses.
- resp_* other than resp_valid hold their last value when no request is accepted.
- An update sampled at edge t is visible to lookups sampled at edge t (bypass) and later.
- GHR changes take effect at the same edge, so a lookup at t+1 indexes with the new GHR.
- No backpressure: ready=1 means every valid is accepted.

## Test plan
- Init: INDEX_WIDTH=4, COUNTER_WIDTH=2, deassert rstn -> ready rises after 16 edges. Then a lookup of every index -> resp_counter=1, resp_taken=0.
- Saturation: COUNTER_WIDTH=3, 10 taken updates to index 5 -> lookup gives 7, taken. Then 10 not-taken updates -> 0, not taken, with no wrap.
- Gshare index/history: GSHARE=1, HISTORY_LEN=4, GHR=4'b1010, pred_pc=0x34 -> resp_index=0xD^0xA=0x7 and resp_ghr=4'b1010. Next GHR=4'b0100 if predicted not-taken.
- Recovery priority: same cycle, lookup plus upd_mispredict=1 with upd_ghr=4'b0011, upd_taken=1 -> GHR=4'b0111 next cycle. The lookup response carries the old GHR.
- Bypass: counter at 1 at index 3, same-cycle taken update and lookup of index 3 -> resp_counter=2, resp_taken=1.
- Reset mid-sweep: assert rstn low at sweep entry 9 -> outputs 0 and GHR 0. After release, a full 16-cycle sweep runs before ready, and updates during it are ignored.
